sb_arbiter: RTL

Two-master arbiter that shares the single SystemBridge slave port between the CPU and a second bus master (the planned DMA engine). It sits between both masters and the bridge. It serialises their accesses with round-robin priority and an optional bounded bus lock, and returns each master's read data and exception flag with a one-cycle ack.

---
 rtl/sb_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sb_arbiter.sv
// sb_arbiter: shares the single SystemBridge slave port between two bus
// masters (CPU on port 0, DMA engine on port 1). Round-robin arbitration,
// optional bounded bus lock, one-cycle access strobe and a registered
// one-cycle ack carrying read data and the bridge exception flag.
module sb_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_LOCK = 16
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              m0_req,
   input  logic              m0_we,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_exc,

   input  logic              m1_req,
   input  logic              m1_we,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_exc,

   output logic              sb_writeEnable,
   output logic              sb_readEnable,
   output logic [ADDR_W-1:0] sb_address,
   output logic [DATA_W-1:0] sb_writeData,
   input  logic [DATA_W-1:0] sb_readData,
   input  logic              sb_exception,

   output logic [1:0]        owner
);

   localparam int LW = $clog2(MAX_LOCK + 1);

   typedef enum logic [2:0] {
      IDLE,
      ACC0,
      ACC1,
      RSP0,
      RSP1,
      HOLD0,
      HOLD1
   } state_t;

   state_t        state;
   logic          last;
   logic [LW-1:0] lcnt;

   logic          pick0;
   logic          lockRoom;

   // Master 0 wins in IDLE when it is the only requester or when master 1
   // was granted most recently; otherwise a pending master 1 gets the port.
   assign pick0 = m0_req & (~m1_req | last);

   // Another locked transaction is allowed only while the run stays below
   // MAX_LOCK, so the forced release happens after exactly MAX_LOCK of them.
   assign lockRoom = ({{(32-LW){1'b0}}, lcnt} + 32'd1) < MAX_LOCK;

   // Arbitration FSM; every output is registered and sb_* are loaded on the
   // transition into an ACC state so they are live for exactly that cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         last           <= 1'b1;
         lcnt           <= '0;
         owner          <= 2'b00;
         m0_ack         <= 1'b0;
         m1_ack         <= 1'b0;
         m0_rdata       <= '0;
         m1_rdata       <= '0;
         m0_exc         <= 1'b0;
         m1_exc         <= 1'b0;
         sb_writeEnable <= 1'b0;
         sb_readEnable  <= 1'b0;
         sb_address     <= '0;
         sb_writeData   <= '0;
      end else begin
         m0_ack         <= 1'b0;
         m1_ack         <= 1'b0;
         sb_writeEnable <= 1'b0;
         sb_readEnable  <= 1'b0;
         sb_address     <= '0;
         sb_writeData   <= '0;
         case (state)
            IDLE: begin
               if (pick0) begin
                  state          <= ACC0;
                  last           <= 1'b0;
                  owner          <= 2'b01;
                  sb_writeEnable <= m0_we;
                  sb_readEnable  <= ~m0_we;
                  sb_address     <= m0_addr;
                  sb_writeData   <= m0_wdata;
               end else if (m1_req) begin
                  state          <= ACC1;
                  last           <= 1'b1;
                  owner          <= 2'b10;
                  sb_writeEnable <= m1_we;
                  sb_readEnable  <= ~m1_we;
                  sb_address     <= m1_addr;
                  sb_writeData   <= m1_wdata;
               end
            end
            ACC0: begin
               m0_rdata <= sb_readData;
               m0_exc   <= sb_exception;
               m0_ack   <= 1'b1;
               state    <= RSP0;
            end
            ACC1: begin
               m1_rdata <= sb_readData;
               m1_exc   <= sb_exception;
               m1_ack   <= 1'b1;
               state    <= RSP1;
            end
            RSP0: begin
               if (m0_lock && lockRoom) begin
                  lcnt  <= lcnt + LW'(1);
                  state <= HOLD0;
               end else begin
                  lcnt  <= '0;
                  state <= IDLE;
                  owner <= 2'b00;
               end
            end
            RSP1: begin
               if (m1_lock && lockRoom) begin
                  lcnt  <= lcnt + LW'(1);
                  state <= HOLD1;
               end else begin
                  lcnt  <= '0;
                  state <= IDLE;
                  owner <= 2'b00;
               end
            end
            HOLD0: begin
               if (m0_req) begin
                  state          <= ACC0;
                  sb_writeEnable <= m0_we;
                  sb_readEnable  <= ~m0_we;
                  sb_address     <= m0_addr;
                  sb_writeData   <= m0_wdata;
               end else if (!m0_lock) begin
                  lcnt  <= '0;
                  state <= IDLE;
                  owner <= 2'b00;
               end
            end
            HOLD1: begin
               if (m1_req) begin
                  state          <= ACC1;
                  sb_writeEnable <= m1_we;
                  sb_readEnable  <= ~m1_we;
                  sb_address     <= m1_addr;
                  sb_writeData   <= m1_wdata;
               end else if (!m1_lock) begin
                  lcnt  <= '0;
                  state <= IDLE;
                  owner <= 2'b00;
               end
            end
            default: begin
               lcnt  <= '0;
               state <= IDLE;
               owner <= 2'b00;
            end
         endcase
      end
   end

endmodule
